// File: rtl/qpsk_dac_pkg.sv
// rtl/qpsk_dac_pkg.sv - shared types and constants for the DAC channel scheduler
// Contents: scheduler state enum, serial frame geometry, default DAC channel addresses.
package qpsk_dac_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_SHIFT,
    ST_GAP,
    ST_LDAC
  } state_t;

  localparam int FRAME_W   = 16;
  // Frame bit 15 is the command bit; 0 selects a register write.
  localparam int WRITE_BIT = 15;
  localparam int ADDR_W    = 3;

  localparam logic [ADDR_W-1:0] DEF_ADDR_A = 3'd0;
  localparam logic [ADDR_W-1:0] DEF_ADDR_B = 3'd1;

endpackage

// File: rtl/dac_channel_scheduler_if.sv
// rtl/dac_channel_scheduler_if.sv - I/Q sample stream bundle feeding the DAC scheduler
// Signals: a_data/a_valid/a_ready (stream A, I), b_data/b_valid/b_ready (stream B, Q).
// Modports: master = sample source (symbol mapper), slave = scheduler.
interface dac_channel_scheduler_if #(
  parameter int DATA_W = 12
);

  logic [DATA_W-1:0] a_data;
  logic              a_valid;
  logic              a_ready;
  logic [DATA_W-1:0] b_data;
  logic              b_valid;
  logic              b_ready;

  modport master (
    output a_data, a_valid, b_data, b_valid,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_data, a_valid, b_data, b_valid,
    output a_ready, b_ready
  );

endinterface

// File: rtl/spi_frame_shifter.sv
// rtl/spi_frame_shifter.sv - 16-bit MSB-first serialiser with divided SCLK
// Ports: clk, rst_n (async active-low); load + word (latch a frame and start it);
//        done (high in the last cycle of the frame); sclk (idles high); sdi.
module spi_frame_shifter
  import qpsk_dac_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [FRAME_W-1:0] word,
  output logic               done,
  output logic               sclk,
  output logic               sdi
);

  localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam int                BIT_W    = $clog2(FRAME_W);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(FRAME_W - 1);

  logic [FRAME_W-1:0] sreg;
  logic [DIV_W-1:0]   div_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic               phase_low;
  logic               active;
  logic               div_wrap;

  assign div_wrap = (div_cnt == DIV_LAST);
  assign done     = active && phase_low && div_wrap && (bit_cnt == BIT_LAST);
  // SDI comes straight from a flop; the register is cleared after the frame so SDI idles low.
  assign sdi      = sreg[FRAME_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg      <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      phase_low <= 1'b0;
      active    <= 1'b0;
      sclk      <= 1'b1;
    end else if (load) begin
      sreg      <= word;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      phase_low <= 1'b0;
      active    <= 1'b1;
      sclk      <= 1'b1;
    end else if (active) begin
      if (!div_wrap) begin
        div_cnt <= div_cnt + 1'b1;
      end else begin
        div_cnt <= '0;
        if (!phase_low) begin
          phase_low <= 1'b1;
          sclk      <= 1'b0;
        end else begin
          // Rising SCLK and the next data bit change together; DAC samples on the fall.
          phase_low <= 1'b0;
          sclk      <= 1'b1;
          if (bit_cnt == BIT_LAST) begin
            active <= 1'b0;
            sreg   <= '0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            sreg    <= {sreg[FRAME_W-2:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: rtl/dac_channel_scheduler.sv
// rtl/dac_channel_scheduler.sv - shares one serial DAC between the I and Q sample streams
// Ports: CLK, RESETn (async active-low); samples (slave stream bundle, A/B handshakes);
//        SCLK, SDI, SYNC_n, LDAC_n (DAC pins); busy (not IDLE); init_done (init frame sent).
module dac_channel_scheduler
  import qpsk_dac_pkg::*;
#(
  parameter int                DATA_W    = 12,
  parameter int                CLK_DIV   = 2,
  parameter int                GAP_CYC   = 2,
  parameter int                LDAC_CYC  = 2,
  parameter logic [FRAME_W-1:0] INIT_WORD = 16'hA000,
  parameter logic [ADDR_W-1:0] ADDR_A    = DEF_ADDR_A,
  parameter logic [ADDR_W-1:0] ADDR_B    = DEF_ADDR_B
) (
  input  logic                    CLK,
  input  logic                    RESETn,
  dac_channel_scheduler_if.slave  samples,
  output logic                    SCLK,
  output logic                    SDI,
  output logic                    SYNC_n,
  output logic                    LDAC_n,
  output logic                    busy,
  output logic                    init_done
);

  // One counter serves both the inter-frame gap and the LDAC pulse.
  localparam int               CNT_MAX   = (GAP_CYC > LDAC_CYC) ? GAP_CYC : LDAC_CYC;
  localparam int               CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] LDAC_LAST = CNT_W'(LDAC_CYC - 1);

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic               last_b;       // last granted stream was B
  logic               flag_a, flag_b;
  logic               frame_init;   // frame in flight is the init word
  logic               frame_b;      // frame in flight carries stream B
  logic               grant_a, grant_b;
  logic               load;
  logic [FRAME_W-1:0] word;
  logic               shift_done;
  logic               gap_end, ldac_end, pair_full;

  assign gap_end   = (cnt == GAP_LAST);
  assign ldac_end  = (cnt == LDAC_LAST);
  // Pair is complete if the finishing frame fills the only missing channel.
  assign pair_full = (flag_a || !frame_b) && (flag_b || frame_b);

  assign samples.a_ready = grant_a;
  assign samples.b_ready = grant_b;

  spi_frame_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk   (CLK),
    .rst_n (RESETn),
    .load  (load),
    .word  (word),
    .done  (shift_done),
    .sclk  (SCLK),
    .sdi   (SDI)
  );

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state <= ST_INIT;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_INIT:  state_next = ST_SHIFT;
      ST_IDLE:  if (grant_a || grant_b) state_next = ST_SHIFT;
      ST_SHIFT: if (shift_done) state_next = ST_GAP;
      ST_GAP:   if (gap_end) state_next = (!frame_init && pair_full) ? ST_LDAC : ST_IDLE;
      ST_LDAC:  if (ldac_end) state_next = ST_IDLE;
      default:  state_next = ST_INIT;
    endcase
  end

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state == ST_IDLE) begin
      // On a tie the stream that did not win last time goes next.
      grant_a = samples.a_valid && (!samples.b_valid || last_b);
      grant_b = samples.b_valid && (!samples.a_valid || !last_b);
    end
    load = (state == ST_INIT) || grant_a || grant_b;
    word = INIT_WORD;
    if (grant_a || grant_b) begin
      word = '0;
      word[WRITE_BIT]                = 1'b0;
      word[WRITE_BIT-1 -: ADDR_W]    = grant_b ? ADDR_B : ADDR_A;
      word[DATA_W-1:0]               = grant_b ? samples.b_data : samples.a_data;
    end
    busy   = (state != ST_IDLE);
    SYNC_n = (state != ST_SHIFT);
    LDAC_n = (state != ST_LDAC);
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      cnt        <= '0;
      last_b     <= 1'b1;
      flag_a     <= 1'b0;
      flag_b     <= 1'b0;
      frame_init <= 1'b1;
      frame_b    <= 1'b0;
      init_done  <= 1'b0;
    end else begin
      if (state != state_next || !(state == ST_GAP || state == ST_LDAC)) cnt <= '0;
      else                                                                cnt <= cnt + 1'b1;
      if (state == ST_INIT) frame_init <= 1'b1;
      if (grant_a || grant_b) begin
        frame_init <= 1'b0;
        frame_b    <= grant_b;
        last_b     <= grant_b;
      end
      if (state == ST_GAP && gap_end) begin
        if (frame_init)   init_done <= 1'b1;
        else if (frame_b) flag_b    <= 1'b1;
        else              flag_a    <= 1'b1;
      end
      if (state == ST_LDAC && ldac_end) begin
        flag_a <= 1'b0;
        flag_b <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dac_channel_scheduler.sv
// tb/tb_dac_channel_scheduler.sv - scoreboard bench for dac_channel_scheduler
module tb_dac_channel_scheduler;

  localparam int          CLK_DIV   = 2;
  localparam int          GAP_CYC   = 2;
  localparam int          LDAC_CYC  = 2;
  localparam logic [15:0] INIT_WORD = 16'hA000;
  localparam int          FRAME_CYC = 32 * CLK_DIV;
  localparam int          LDAC_LAT  = 1 + FRAME_CYC + GAP_CYC;

  logic CLK = 1'b0;
  logic RESETn = 1'b0;
  logic SCLK, SDI, SYNC_n, LDAC_n, busy, init_done;

  dac_channel_scheduler_if #(.DATA_W(12)) samples();

  dac_channel_scheduler #(
    .DATA_W    (12),
    .CLK_DIV   (CLK_DIV),
    .GAP_CYC   (GAP_CYC),
    .LDAC_CYC  (LDAC_CYC),
    .INIT_WORD (INIT_WORD),
    .ADDR_A    (3'd0),
    .ADDR_B    (3'd1)
  ) dut (
    .CLK       (CLK),
    .RESETn    (RESETn),
    .samples   (samples),
    .SCLK      (SCLK),
    .SDI       (SDI),
    .SYNC_n    (SYNC_n),
    .LDAC_n    (LDAC_n),
    .busy      (busy),
    .init_done (init_done)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_q[$];
  int frames_pushed = 0, frames_seen = 0;
  int exp_ldac = 0, ldac_cnt = 0;
  int exp_a = 0, exp_b = 0, a_rdy_cyc = 0, b_rdy_cyc = 0;
  bit m_flag_a = 0, m_flag_b = 0;
  int cyc = 0, hs_cyc = 0;
  bit hs_pending = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected frame plus the bench's own model of the pair flags.
  task automatic push_frame(input bit is_b, input logic [11:0] d);
    logic [15:0] f;
    f = {1'b0, (is_b ? 3'd1 : 3'd0), d};
    exp_q.push_back(f);
    frames_pushed++;
    if (is_b) begin m_flag_b = 1; exp_b++; end
    else      begin m_flag_a = 1; exp_a++; end
    if (m_flag_a && m_flag_b) begin
      exp_ldac++;
      m_flag_a = 0;
      m_flag_b = 0;
    end
  endtask

  task automatic stream(input bit is_b, input int n, input logic [11:0] base);
    bit got;
    @(posedge CLK); #1;
    for (int k = 0; k < n; k++) begin
      if (is_b) begin samples.b_data = 12'(base + k); samples.b_valid = 1'b1; end
      else      begin samples.a_data = 12'(base + k); samples.a_valid = 1'b1; end
      got = 0;
      for (int t = 0; t < 400 && !got; t++) begin
        @(negedge CLK);
        got = is_b ? samples.b_ready : samples.a_ready;
      end
      if (!got) begin
        if (is_b) check_eq("b_accept_timeout", 32'(got), 1);
        else      check_eq("a_accept_timeout", 32'(got), 1);
      end
      @(posedge CLK); #1;
    end
    if (is_b) samples.b_valid = 1'b0;
    else      samples.a_valid = 1'b0;
  endtask

  task automatic wait_quiet;
    int t;
    t = 0;
    do begin
      @(negedge CLK);
      t++;
    end while ((busy || exp_q.size() != 0) && t < 3000);
    if (t >= 3000) check_eq("quiet_timeout", {30'd0, busy, exp_q.size() != 0}, 0);
    repeat (6) @(negedge CLK);
  endtask

  always @(posedge CLK) cyc++;

  logic        prev_sync = 1, prev_sclk = 1, prev_ldac = 1;
  logic [15:0] shreg = '0;
  int          bit_n = 0, sync_len = 0, ldac_len = 0;

  always @(negedge CLK) begin
    if (!RESETn) begin
      prev_sync  = 1; prev_sclk = 1; prev_ldac = 1;
      bit_n      = 0; sync_len  = 0; ldac_len  = 0;
      hs_pending = 0;
    end else begin
      if (!SYNC_n) begin
        if (prev_sync) begin
          bit_n    = 0;
          sync_len = 0;
          if (hs_pending) begin
            check_eq("hs_to_sync", cyc - hs_cyc, 1);
            hs_pending = 0;
          end
        end
        sync_len++;
        if (prev_sclk && !SCLK) begin
          shreg = {shreg[14:0], SDI};
          bit_n++;
        end
      end else if (!prev_sync) begin
        frames_seen++;
        check_eq("frame_bits", bit_n, 16);
        check_eq("frame_len", sync_len, FRAME_CYC);
        check_eq("sclk_idle", SCLK, 1);
        if (exp_q.size() != 0) check_eq("frame_word", shreg, exp_q.pop_front());
      end
      if (!LDAC_n) begin
        if (prev_ldac) begin
          ldac_len = 0;
          check_eq("ldac_latency", cyc - hs_cyc, LDAC_LAT);
        end
        ldac_len++;
      end else if (!prev_ldac) begin
        check_eq("ldac_width", ldac_len, LDAC_CYC);
        ldac_cnt++;
      end
      if (samples.a_ready) a_rdy_cyc++;
      if (samples.b_ready) b_rdy_cyc++;
      if ((samples.a_valid && samples.a_ready) || (samples.b_valid && samples.b_ready)) begin
        check_eq("ready_onehot", samples.a_ready & samples.b_ready, 0);
        check_eq("busy_at_hs", busy, 0);
        hs_cyc     = cyc;
        hs_pending = 1;
      end
      prev_sync = SYNC_n;
      prev_sclk = SCLK;
      prev_ldac = LDAC_n;
    end
  end

  initial begin
    samples.a_valid = 1'b0;
    samples.b_valid = 1'b0;
    samples.a_data  = '0;
    samples.b_data  = '0;
    repeat (3) @(posedge CLK);
    #1;
    check_eq("rst_sclk", SCLK, 1);
    check_eq("rst_sdi", SDI, 0);
    check_eq("rst_sync", SYNC_n, 1);
    check_eq("rst_ldac", LDAC_n, 1);
    check_eq("rst_a_ready", samples.a_ready, 0);
    check_eq("rst_b_ready", samples.b_ready, 0);
    check_eq("rst_busy", busy, 1);
    check_eq("rst_init_done", init_done, 0);

    exp_q.push_back(INIT_WORD);
    frames_pushed++;
    @(negedge CLK);
    RESETn = 1'b1;
    wait_quiet();
    check_eq("init_done_set", init_done, 1);
    check_eq("idle_busy", busy, 0);
    check_eq("init_no_ldac", ldac_cnt, 0);

    push_frame(0, 12'hABC);
    stream(0, 1, 12'hABC);
    wait_quiet();
    check_eq("a_only_ldac", ldac_cnt, exp_ldac);
    check_eq("a_ready_cycles", a_rdy_cyc, exp_a);

    push_frame(1, 12'h123);
    stream(1, 1, 12'h123);
    wait_quiet();
    check_eq("pair_ldac", ldac_cnt, exp_ldac);
    check_eq("b_ready_cycles", b_rdy_cyc, exp_b);

    for (int k = 0; k < 4; k++) begin
      push_frame(0, 12'(12'h100 + k));
      push_frame(1, 12'(12'h200 + k));
    end
    fork
      stream(0, 4, 12'h100);
      stream(1, 4, 12'h200);
    join
    wait_quiet();
    check_eq("alt_ldac", ldac_cnt, exp_ldac);
    check_eq("alt_a_ready", a_rdy_cyc, exp_a);
    check_eq("alt_b_ready", b_rdy_cyc, exp_b);

    for (int k = 1; k <= 3; k++) push_frame(0, 12'(k));
    stream(0, 3, 12'h001);
    wait_quiet();
    check_eq("repeat_a_ldac", ldac_cnt, exp_ldac);
    push_frame(1, 12'h7FF);
    stream(1, 1, 12'h7FF);
    wait_quiet();
    check_eq("repeat_pair_ldac", ldac_cnt, exp_ldac);

    push_frame(0, 12'h555);
    stream(0, 1, 12'h555);
    repeat (28) @(posedge CLK);
    @(negedge CLK);
    check_eq("sync_before_rst", SYNC_n, 0);
    RESETn = 1'b0;
    #1;
    check_eq("abort_sync", SYNC_n, 1);
    check_eq("abort_sclk", SCLK, 1);
    check_eq("abort_busy", busy, 1);
    check_eq("abort_init_done", init_done, 0);
    void'(exp_q.pop_back());
    frames_pushed--;
    m_flag_a = 0;
    m_flag_b = 0;
    exp_q.push_back(INIT_WORD);
    frames_pushed++;
    repeat (3) @(negedge CLK);
    RESETn = 1'b1;
    wait_quiet();
    repeat (150) @(negedge CLK);
    check_eq("reinit_done", init_done, 1);
    check_eq("no_resend_frames", frames_seen, frames_pushed);
    check_eq("final_ldac", ldac_cnt, exp_ldac);
    check_eq("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
